// File: rtl/jtflane_vtimer.sv
// jtflane_vtimer: video timing counters, sync/blank decode, VBLANK IRQ and periodic NMI for Fast Lane
module jtflane_vtimer #(
    parameter int HTOTAL   = 384,
    parameter int HB_START = 256,
    parameter int HS_START = 296,
    parameter int HS_END   = 328,
    parameter int VTOTAL   = 264,
    parameter int VB_START = 240,
    parameter int VB_END   = 16,
    parameter int VS_START = 248,
    parameter int VS_END   = 256,
    parameter int NMI_LEN  = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen6,
    input  logic       cpu_cen,
    input  logic       ctrl_cs,
    input  logic       cpu_rnw,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [8:0] hdump,
    output logic [8:0] vdump,
    output logic       hs,
    output logic       vs,
    output logic       lhbl,
    output logic       lvbl,
    output logic       flip,
    output logic       frame,
    output logic       gfx_irqn,
    output logic       gfx_nmin
);
    localparam int CW = $clog2(NMI_LEN + 1);
    localparam logic [CW-1:0] NMI_W = CW'(NMI_LEN);

    logic [8:0]    h_nx, v_nx;
    logic          h_wrap, v_wrap, wr, irq_set, irq_clr, nmi_start, nmi_off;
    logic          irq_en, nmi_en, irq_latch;
    logic [CW-1:0] nmi_cnt, cnt_nx;

    // next counter values and the events that hang off them
    always_comb begin
        h_wrap    = hdump == 9'(HTOTAL - 1);
        v_wrap    = vdump == 9'(VTOTAL - 1);
        h_nx      = h_wrap ? 9'd0 : hdump + 9'd1;
        v_nx      = h_wrap ? (v_wrap ? 9'd0 : vdump + 9'd1) : vdump;
        wr        = ctrl_cs & ~cpu_rnw & cpu_cen;
        irq_set   = cen6 & irq_en & h_wrap & (v_nx == 9'(VB_START));
        irq_clr   = wr & ((cpu_addr == 2'd1) | ((cpu_addr == 2'd0) & ~cpu_dout[0]));
        nmi_start = cen6 & nmi_en & h_wrap & (v_nx[4:0] == 5'd0);
        nmi_off   = wr & (cpu_addr == 2'd0) & ~cpu_dout[1];
        cnt_nx    = nmi_off ? '0 : nmi_start ? NMI_W :
                    (cen6 && nmi_cnt != '0) ? nmi_cnt - CW'(1) : nmi_cnt;
    end

    // counters and decoded timing, all moving together on the pixel enable
    always_ff @(posedge clk) begin
        if (rst) begin
            hdump <= 9'd0;
            vdump <= 9'd0;
            frame <= 1'b0;
            lhbl  <= 1'b1;
            lvbl  <= 1'b0;
            hs    <= 1'b0;
            vs    <= 1'b0;
        end else if (cen6) begin
            hdump <= h_nx;
            vdump <= v_nx;
            if (h_wrap && v_wrap) frame <= ~frame;
            lhbl  <= h_nx < 9'(HB_START);
            lvbl  <= (v_nx >= 9'(VB_END)) && (v_nx < 9'(VB_START));
            hs    <= (h_nx >= 9'(HS_START)) && (h_nx < 9'(HS_END));
            vs    <= (v_nx >= 9'(VS_START)) && (v_nx < 9'(VS_END));
        end
    end

    // CPU control register at address 0
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            nmi_en <= 1'b0;
            flip   <= 1'b0;
        end else if (wr && cpu_addr == 2'd0) begin
            irq_en <= cpu_dout[0];
            nmi_en <= cpu_dout[1];
            flip   <= cpu_dout[3];
        end
    end

    // VBLANK IRQ latch; a new vblank beats a simultaneous acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_latch <= 1'b0;
            gfx_irqn  <= 1'b1;
        end else begin
            irq_latch <= irq_set | (irq_latch & ~irq_clr);
            gfx_irqn  <= ~(irq_set | (irq_latch & ~irq_clr));
        end
    end

    // NMI pulse width counter; the line stays low while ticks remain
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_cnt  <= '0;
            gfx_nmin <= 1'b1;
        end else begin
            nmi_cnt  <= cnt_nx;
            gfx_nmin <= cnt_nx == '0;
        end
    end
endmodule

// File: tb/tb_jtflane_vtimer.sv
// tb_jtflane_vtimer: randomized check of jtflane_vtimer against a tick-count reference model
module tb_jtflane_vtimer;
    localparam int HT = 40, HB = 32, HSS = 34, HSE = 37;
    localparam int VT = 72, VBS = 60, VBE = 4, VSS = 63, VSE = 66, NL = 8;

    logic       clk = 0, rst = 1, cen6 = 0, cpu_cen = 0, ctrl_cs = 0, cpu_rnw = 1;
    logic [1:0] cpu_addr = 0;
    logic [7:0] cpu_dout = 0;
    logic [8:0] hdump, vdump;
    logic       hs, vs, lhbl, lvbl, flip, frame, gfx_irqn, gfx_nmin;

    jtflane_vtimer #(.HTOTAL(HT), .HB_START(HB), .HS_START(HSS), .HS_END(HSE),
        .VTOTAL(VT), .VB_START(VBS), .VB_END(VBE), .VS_START(VSS), .VS_END(VSE),
        .NMI_LEN(NL)) dut (
        .clk(clk), .rst(rst), .cen6(cen6), .cpu_cen(cpu_cen), .ctrl_cs(ctrl_cs),
        .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .hdump(hdump), .vdump(vdump), .hs(hs), .vs(vs), .lhbl(lhbl), .lvbl(lvbl),
        .flip(flip), .frame(frame), .gfx_irqn(gfx_irqn), .gfx_nmin(gfx_nmin));

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int t = 0, nstart = -1, toggles = 0, falls = 0, lows = 0;
    bit m_irq_en = 0, m_nmi_en = 0, m_flip = 0, m_latch = 0, prev_frame = 0, prev_nmin = 1;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d tick=%0d", tag, got, exp, t);
        end
    endtask

    function automatic int mh(); return t % HT; endfunction
    function automatic int mv(); return (t / HT) % VT; endfunction

    task automatic cyc(input bit c, input bit cs, input bit rnw, input bit cc,
                       input logic [1:0] a, input logic [7:0] d);
        bit wr;
        int h, v;
        @(negedge clk);
        cen6 = c; ctrl_cs = cs; cpu_rnw = rnw; cpu_cen = cc; cpu_addr = a; cpu_dout = d;
        @(posedge clk);
        #1;
        wr = cs && !rnw && cc;
        if (rst) begin
            t = 0; nstart = -1; m_irq_en = 0; m_nmi_en = 0; m_flip = 0; m_latch = 0;
        end else begin
            bit set = 0;
            if (c) begin
                t++;
                if (m_irq_en && mh() == 0 && mv() == VBS) set = 1;
                if (m_nmi_en && mh() == 0 && mv() % 32 == 0) nstart = t;
            end
            if (set) m_latch = 1;
            else if (wr && (a == 1 || (a == 0 && !d[0]))) m_latch = 0;
            if (wr && a == 0 && !d[1]) nstart = -1;
            if (wr && a == 0) begin m_irq_en = d[0]; m_nmi_en = d[1]; m_flip = d[3]; end
        end
        h = mh(); v = mv();
        chk("hdump", hdump, h);
        chk("vdump", vdump, v);
        chk("lhbl", lhbl, int'(h < HB));
        chk("lvbl", lvbl, int'(v >= VBE && v < VBS));
        chk("hs", hs, int'(h >= HSS && h < HSE));
        chk("vs", vs, int'(v >= VSS && v < VSE));
        chk("frame", frame, (t / (HT * VT)) % 2);
        chk("flip", flip, int'(m_flip));
        chk("gfx_irqn", gfx_irqn, int'(!m_latch));
        chk("gfx_nmin", gfx_nmin, int'(!(nstart >= 0 && t - nstart < NL)));
        if (frame !== prev_frame) toggles++;
        if (prev_nmin === 1'b1 && gfx_nmin === 1'b0) falls++;
        if (gfx_nmin === 1'b0) lows++;
        prev_frame = frame;
        prev_nmin = gfx_nmin;
    endtask

    task automatic idle(input bit c); cyc(c, 0, 1, 0, 2'd0, 8'd0); endtask
    task automatic wrreg(input logic [1:0] a, input logic [7:0] d); cyc(0, 1, 0, 1, a, d); endtask

    task automatic wait_line(input int target);
        int n = 0;
        while (!(mv() == target && mh() == 0) && n < HT * VT + 4) begin idle(1); n++; end
        chk("reach_line", vdump, target);
    endtask

    initial begin
        idle(1); idle(0);
        rst = 0;
        idle(0);
        toggles = 0;
        for (int i = 0; i < 2 * HT * VT * 4; i++) idle(i % 4 == 0);
        chk("frame_toggles", toggles, 2);

        wait_line(20);
        wrreg(0, 8'h01);
        wait_line(VBS);
        chk("irq_at_vbs", gfx_irqn, 0);
        wait_line(3);
        chk("irq_across_wrap", gfx_irqn, 0);
        wrreg(1, 8'h00);
        chk("irq_ack", gfx_irqn, 1);

        wrreg(0, 8'h00);
        wait_line(VBS + 2);
        wrreg(0, 8'h01);
        wait_line(VBS - 1);
        chk("late_enable_no_irq", gfx_irqn, 1);
        for (int i = 0; i < HT; i++) idle(1);
        chk("late_enable_next_frame", gfx_irqn, 0);

        wrreg(0, 8'h02);
        chk("nmi_disable_irq_ack", gfx_irqn, 1);
        wait_line(VT - 1);
        falls = 0; lows = 0;
        for (int i = 0; i < HT * VT; i++) idle(1);
        chk("nmi_pulses", falls, 3);
        chk("nmi_low_ticks", lows, 3 * NL);
        wait_line(32);
        idle(1); idle(1);
        chk("nmi_mid_pulse", gfx_nmin, 0);
        wrreg(0, 8'h00);
        chk("nmi_forced_high", gfx_nmin, 1);
        falls = 0;
        for (int i = 0; i < HT * VT; i++) idle(1);
        chk("nmi_no_more", falls, 0);

        wrreg(0, 8'h08);
        chk("flip_set", flip, 1);
        cyc(0, 1, 0, 0, 2'd0, 8'h00);
        chk("flip_no_cen", flip, 1);
        cyc(1, 1, 1, 1, 2'd0, 8'h00);
        chk("flip_read", flip, 1);

        for (int i = 0; i < 6000; i++) begin
            bit cs = $urandom_range(0, 99) < 8;
            cyc($urandom_range(0, 99) < 60, cs, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                2'($urandom_range(0, 3)), 8'($urandom));
        end

        wrreg(0, 8'h09);
        wait_line(VBS + 5);
        for (int i = 0; i < 30; i++) idle(1);
        chk("pre_rst_irq", gfx_irqn, 0);
        rst = 1;
        idle(0);
        rst = 0;
        chk("rst_irqn", gfx_irqn, 1);
        chk("rst_h", hdump, 0);
        chk("rst_v", vdump, 0);
        chk("rst_flip", flip, 0);
        for (int i = 0; i < 300; i++) idle($urandom_range(0, 1) == 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
